nx_node_control_inputs: RTL and testbench
=========================================

# nx_node_control_inputs

Receive side of the node signal-state protocol. Accepts inbound `NODE_COMMAND_SIG_STATE` messages and local loopback updates, and maintains two vectors per input: a current (core-visible) vector and a next (sequential) vector. Sequential updates are staged and promoted on a simulation-cycle trigger. The block sits inside node control, between the inbound message distributor and the logic core's input port, and mirrors the output-change detector on the transmit side.

## Interface
- `INPUTS`, 32: number of core inputs; index values at or above `INPUTS` are out of range.
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `idle_o` output 1: no update in flight.
- `msg_data_i` input `node_message_t`: inbound message, interpreted as `node_sig_state_t`.
- `msg_valid_i` input 1: message valid.
- `msg_ready_o` output 1: message accepted when `msg_valid_i && msg_ready_o`.
- `loopback_index_i` input `IOR_WIDTH`: loopback input index.
- `loopback_state_i` input 1: loopback value.
- `loopback_valid_i` input 1: loopback strobe. It has no backpressure and must never be dropped.
- `trigger_i` input 1: simulation-cycle boundary pulse that promotes the next vector to the current vector.
- `core_inputs_o` output `INPUTS`: current input vector to the core.
- `core_update_o` output 1: one-cycle pulse; `core_inputs_o` changed at the previous edge.

## Operation
- **State.** `curr_q[INPUTS]` and `next_q[INPUTS]`, both reset to 0. `core_inputs_o = curr_q`.
- **Arbitration.**
  - Loopback has absolute priority.
  - `msg_ready_o = !rst_i && !loopback_valid_i`.
  - A message is stalled, not dropped, while loopback is active.
- **Message decode.**
  - Fields used: `header.command`, `index` (`INPUT_WIDTH` bits), `is_seq`, `state`.
  - A command other than `NODE_COMMAND_SIG_STATE` is accepted and discarded with no state change.
  - An index of `INPUTS` or above is accepted and discarded.
- **Loopback decode.** Always treated as sequential (`is_seq=1`). An out-of-range index is discarded.
- **Update at each edge.** One update `u` = {idx, val, seq} per cycle, taken from loopback or the accepted message.
  - Combinational update (`seq=0`): `curr[idx] <= val` and `next[idx] <= val`.
  - Sequential update (`seq=1`): `next[idx] <= val`; `curr` is unchanged.
  - `trigger_i`: `curr <= next`, with every bit of `next` reflecting any same-cycle update to `next` (see next item).
- **Same-cycle `trigger_i` and update.** The update's effect on `next` is applied before promotion.
  - A combinational update is therefore visible in `curr` after the edge.
  - A sequential update to the same index is also promoted on that trigger.
  - Rule: `curr_d = trigger_i ? next_d : (comb ? curr with bit written : curr_q)`.
- **`core_update_o`.** Registered: `core_update_o <= (curr_d != curr_q)`.
- **`idle_o`.** `!(msg_valid_i || loopback_valid_i || core_update_o)`.
- **Reset mid-operation.**
  - All state clears asynchronously.
  - A message presented during reset is not accepted (`msg_ready_o=0`) and must be held by the sender.

## Timing
- **Reset values:** `core_inputs_o=0`, `core_update_o=0`, `msg_ready_o=0`, `idle_o` = the combinational expression above with `core_update_o=0`.
- **Latency:**
  - An update accepted in cycle N is written at the end of N.
  - A combinational update appears on `core_inputs_o` in cycle N+1, with `core_update_o=1` in N+1 if the value changed.
  - A sequential update appears in the cycle after the next `trigger_i`.
- **Throughput:** one update per cycle. The message path sustains 1/cycle when loopback is idle.
- **Handshake:**
  - `msg_ready_o` is combinational from `loopback_valid_i` only. It never depends on `msg_valid_i`.
  - The sender must hold `msg_data_i` stable while valid and not ready.
- **`trigger_i`:** single-cycle pulse. Back-to-back triggers promote twice; the second is idempotent unless updates intervene.

## Test plan
- **Combinational message.** Message idx=5, state=1, is_seq=0, ready high in cycle 0 -> `core_inputs_o[5]=1` in cycle 1, `core_update_o=1` in cycle 1, 0 in cycle 2.
- **Sequential message.** idx=3, state=1, is_seq=1 in cycle 0 -> `core_inputs_o[3]` stays 0 until a `trigger_i` pulse in cycle 4, then reads 1 from cycle 5.
- **Loopback collision.** Loopback idx=7 and a message idx=2 (comb) both valid in cycle 0 -> `msg_ready_o=0` in cycle 0; loopback written to `next[7]`; the message is accepted in cycle 1 and `core_inputs_o[2]=1` in cycle 2.
- **Trigger with same-cycle updates.** `trigger_i` in the same cycle as sequential idx=9 state=1, then separately as comb idx=9 state=0 -> `core_inputs_o[9]=1` after the first edge, 0 after the second.
- **Discards.** Message with a non-SIG_STATE command, then a SIG_STATE message with idx=`INPUTS` -> both handshake complete, `core_inputs_o` and `next` unchanged, `core_update_o` stays 0.
- **Reset mid-stream.** Assert `rst_i` while `msg_valid_i=1` after prior updates -> `core_inputs_o=0` immediately, `msg_ready_o=0` during reset, and the held message is accepted in the first cycle after release.

Source files
------------

// File: rtl/nx_node_control_inputs_pkg.sv
// Node message types shared by the node-control receive and transmit paths.
package nx_node_control_inputs_pkg;

    localparam int unsigned MSG_WIDTH   = 32;
    localparam int unsigned IOR_WIDTH   = 8;
    localparam int unsigned INPUT_WIDTH = 8;
    localparam int unsigned PAD_WIDTH   = 12;

    typedef enum logic [1:0] {
        NODE_COMMAND_SIG_STATE = 2'd0,
        NODE_COMMAND_MEMORY    = 2'd1,
        NODE_COMMAND_CONTROL   = 2'd2,
        NODE_COMMAND_TRACE     = 2'd3
    } node_command_t;

    typedef struct packed {
        logic [3:0]    row;
        logic [3:0]    column;
        node_command_t command;
    } node_header_t;

    typedef struct packed {
        node_header_t header;
        logic [21:0]  payload;
    } node_message_t;

    typedef struct packed {
        node_header_t           header;
        logic [INPUT_WIDTH-1:0] index;
        logic                   is_seq;
        logic                   state;
        logic [PAD_WIDTH-1:0]   padding;
    } node_sig_state_t;

endpackage

// File: rtl/nx_node_control_inputs.sv
// Receive side of the node signal-state protocol: maintains the current
// (core-visible) and next (sequential) input vectors.
module nx_node_control_inputs
    import nx_node_control_inputs_pkg::*;
#(
    parameter int unsigned INPUTS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 idle_o,
    input  node_message_t        msg_data_i,
    input  logic                 msg_valid_i,
    output logic                 msg_ready_o,
    input  logic [IOR_WIDTH-1:0] loopback_index_i,
    input  logic                 loopback_state_i,
    input  logic                 loopback_valid_i,
    input  logic                 trigger_i,
    output logic [INPUTS-1:0]    core_inputs_o,
    output logic                 core_update_o
);

    localparam int unsigned IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    node_sig_state_t   sig;
    logic              msg_fire;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_val;
    logic              upd_seq;
    logic [INPUTS-1:0] curr_q;
    logic [INPUTS-1:0] next_q;
    logic [INPUTS-1:0] curr_w;
    logic [INPUTS-1:0] curr_d;
    logic [INPUTS-1:0] next_d;
    logic              update_q;
    logic              unused_fields;

    assign sig           = node_sig_state_t'(msg_data_i);
    assign unused_fields = ^{sig.header.row, sig.header.column, sig.padding};

    // Loopback has absolute priority and stalls the message path.
    assign msg_ready_o = !rst_i && !loopback_valid_i;
    assign msg_fire    = msg_valid_i && msg_ready_o;

    // Select the single update for this cycle.
    always_comb begin
        upd_valid = 1'b0;
        upd_idx   = '0;
        upd_val   = 1'b0;
        upd_seq   = 1'b0;
        if (loopback_valid_i) begin
            upd_valid = 32'(loopback_index_i) < INPUTS;
            upd_idx   = IDX_W'(loopback_index_i);
            upd_val   = loopback_state_i;
            upd_seq   = 1'b1;
        end else if (msg_fire) begin
            upd_valid = (sig.header.command == NODE_COMMAND_SIG_STATE) &&
                        (32'(sig.index) < INPUTS);
            upd_idx   = IDX_W'(sig.index);
            upd_val   = sig.state;
            upd_seq   = sig.is_seq;
        end
    end

    // Apply the update to next first so a same-cycle trigger promotes it.
    always_comb begin
        next_d = next_q;
        curr_w = curr_q;
        if (upd_valid) begin
            next_d[upd_idx] = upd_val;
            if (!upd_seq) begin
                curr_w[upd_idx] = upd_val;
            end
        end
        curr_d = trigger_i ? next_d : curr_w;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            curr_q   <= '0;
            next_q   <= '0;
            update_q <= 1'b0;
        end else begin
            curr_q   <= curr_d;
            next_q   <= next_d;
            update_q <= (curr_d != curr_q);
        end
    end

    assign core_inputs_o = curr_q;
    assign core_update_o = update_q;
    assign idle_o        = !(msg_valid_i || loopback_valid_i || update_q);

endmodule

// File: tb/tb_nx_node_control_inputs.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// vector-level reference model of the current/next input state.
module tb_nx_node_control_inputs;
    import nx_node_control_inputs_pkg::*;

    localparam int unsigned INPUTS = 32;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 idle_o;
    node_message_t        msg_data_i;
    logic                 msg_valid_i = 1'b0;
    logic                 msg_ready_o;
    logic [IOR_WIDTH-1:0] loopback_index_i = '0;
    logic                 loopback_state_i = 1'b0;
    logic                 loopback_valid_i = 1'b0;
    logic                 trigger_i = 1'b0;
    logic [INPUTS-1:0]    core_inputs_o;
    logic                 core_update_o;

    nx_node_control_inputs #(.INPUTS(INPUTS)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .idle_o           (idle_o),
        .msg_data_i       (msg_data_i),
        .msg_valid_i      (msg_valid_i),
        .msg_ready_o      (msg_ready_o),
        .loopback_index_i (loopback_index_i),
        .loopback_state_i (loopback_state_i),
        .loopback_valid_i (loopback_valid_i),
        .trigger_i        (trigger_i),
        .core_inputs_o    (core_inputs_o),
        .core_update_o    (core_update_o)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus fields for the message being offered.
    logic              m_valid = 1'b0;
    node_command_t     m_cmd   = NODE_COMMAND_SIG_STATE;
    int unsigned       m_idx   = 0;
    logic              m_seq   = 1'b0;
    logic              m_state = 1'b0;

    // Reference model state.
    logic [INPUTS-1:0] curr_m   = '0;
    logic [INPUTS-1:0] next_m   = '0;
    logic              exp_upd  = 1'b0;
    logic              last_acc = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clear_stim();
        m_valid          = 1'b0;
        loopback_valid_i = 1'b0;
        trigger_i        = 1'b0;
    endtask

    task automatic offer(input node_command_t cmd, input int unsigned idx, input logic seq, input logic st);
        m_valid = 1'b1;
        m_cmd   = cmd;
        m_idx   = idx;
        m_seq   = seq;
        m_state = st;
    endtask

    // One clock: drive current stimulus, check combinational outputs,
    // advance the model at the edge, then check registered outputs.
    task automatic cycle();
        node_sig_state_t   s;
        logic [INPUTS-1:0] n_curr;
        logic [INPUTS-1:0] n_next;
        logic              accepted;
        s         = '0;
        s.header.command = m_cmd;
        s.index   = INPUT_WIDTH'(m_idx);
        s.is_seq  = m_seq;
        s.state   = m_state;
        msg_data_i  = node_message_t'(s);
        msg_valid_i = m_valid;
        if (rst_i) begin
            curr_m  = '0;
            next_m  = '0;
            exp_upd = 1'b0;
        end
        #1;
        check("ready", 64'(msg_ready_o), 64'(!rst_i && !loopback_valid_i));
        check("idle", 64'(idle_o), 64'(!(m_valid || loopback_valid_i || exp_upd)));
        if (rst_i) check("rst_curr", 64'(core_inputs_o), 64'd0);

        accepted = m_valid && !rst_i && !loopback_valid_i;
        n_curr   = curr_m;
        n_next   = next_m;
        if (!rst_i) begin
            if (loopback_valid_i) begin
                if (int'(loopback_index_i) < INPUTS) n_next[loopback_index_i] = loopback_state_i;
            end else if (accepted && m_cmd == NODE_COMMAND_SIG_STATE && m_idx < INPUTS) begin
                n_next[m_idx] = m_state;
                if (!m_seq) n_curr[m_idx] = m_state;
            end
            if (trigger_i) n_curr = n_next;
        end

        @(posedge clk_i);
        if (!rst_i) begin
            exp_upd = (n_curr != curr_m);
            curr_m  = n_curr;
            next_m  = n_next;
        end
        last_acc = accepted;
        @(negedge clk_i);
        check("curr", 64'(core_inputs_o), 64'(curr_m));
        check("upd", 64'(core_update_o), 64'(exp_upd));
    endtask

    initial begin
        clear_stim();
        @(negedge clk_i);
        cycle();
        cycle();
        rst_i = 1'b0;
        cycle();

        // Combinational message.
        offer(NODE_COMMAND_SIG_STATE, 5, 1'b0, 1'b1);
        cycle();
        check("comb5_bit", 64'(core_inputs_o[5]), 64'd1);
        check("comb5_upd", 64'(core_update_o), 64'd1);
        clear_stim();
        cycle();
        check("comb5_upd_clr", 64'(core_update_o), 64'd0);

        // Sequential message held until trigger.
        offer(NODE_COMMAND_SIG_STATE, 3, 1'b1, 1'b1);
        cycle();
        clear_stim();
        for (int i = 0; i < 3; i++) begin
            check("seq3_hold", 64'(core_inputs_o[3]), 64'd0);
            cycle();
        end
        trigger_i = 1'b1;
        cycle();
        trigger_i = 1'b0;
        check("seq3_promoted", 64'(core_inputs_o[3]), 64'd1);

        // Loopback collision stalls the message one cycle.
        offer(NODE_COMMAND_SIG_STATE, 2, 1'b0, 1'b1);
        loopback_valid_i = 1'b1;
        loopback_index_i = 8'd7;
        loopback_state_i = 1'b1;
        cycle();
        check("coll_stall", 64'(last_acc), 64'd0);
        check("coll_bit2_pre", 64'(core_inputs_o[2]), 64'd0);
        loopback_valid_i = 1'b0;
        cycle();
        check("coll_bit2", 64'(core_inputs_o[2]), 64'd1);
        check("coll_bit7_staged", 64'(core_inputs_o[7]), 64'd0);
        clear_stim();

        // Trigger coinciding with sequential then combinational updates.
        offer(NODE_COMMAND_SIG_STATE, 9, 1'b1, 1'b1);
        trigger_i = 1'b1;
        cycle();
        check("trig_seq9", 64'(core_inputs_o[9]), 64'd1);
        check("trig_bit7", 64'(core_inputs_o[7]), 64'd1);
        offer(NODE_COMMAND_SIG_STATE, 9, 1'b0, 1'b0);
        cycle();
        check("trig_comb9", 64'(core_inputs_o[9]), 64'd0);
        clear_stim();

        // Discards: wrong command, then out-of-range index.
        offer(NODE_COMMAND_CONTROL, 4, 1'b0, 1'b1);
        cycle();
        check("disc_cmd_acc", 64'(last_acc), 64'd1);
        offer(NODE_COMMAND_SIG_STATE, INPUTS, 1'b0, 1'b1);
        cycle();
        check("disc_idx_acc", 64'(last_acc), 64'd1);
        clear_stim();
        trigger_i = 1'b1;
        cycle();
        trigger_i = 1'b0;
        check("disc_bit4", 64'(core_inputs_o[4]), 64'd0);

        // Reset mid-stream with a held message.
        offer(NODE_COMMAND_SIG_STATE, 11, 1'b0, 1'b1);
        rst_i = 1'b1;
        cycle();
        check("rst_no_acc", 64'(last_acc), 64'd0);
        rst_i = 1'b0;
        cycle();
        check("rst_held_acc", 64'(last_acc), 64'd1);
        check("rst_bit11", 64'(core_inputs_o[11]), 64'd1);
        clear_stim();

        // Randomized traffic; the sender holds its message until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!m_valid || last_acc) begin
                m_valid = ($urandom_range(0, 3) != 0);
                m_cmd   = ($urandom_range(0, 7) == 0) ? node_command_t'($urandom_range(1, 3))
                                                      : NODE_COMMAND_SIG_STATE;
                m_idx   = $urandom_range(0, 35);
                m_seq   = 1'($urandom);
                m_state = 1'($urandom);
            end
            loopback_valid_i = ($urandom_range(0, 3) == 0);
            loopback_index_i = IOR_WIDTH'($urandom_range(0, 35));
            loopback_state_i = 1'($urandom);
            trigger_i        = ($urandom_range(0, 5) == 0);
            rst_i            = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst_i = 1'b0;
        clear_stim();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
